cv32e40p_fault_monitor: RTL and testbench



---
 rtl/cv32e40p_fault_pkg.sv | 14 +
 rtl/cv32e40p_fault_counter.sv | 65 ++++++
 rtl/cv32e40p_fault_monitor.sv | 127 ++++++++++++
 tb/tb_cv32e40p_fault_monitor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_fault_pkg.sv
// Shared types for the CV32E40P fault monitor.
// Clear-handshake states and counting modes.
package cv32e40p_fault_pkg;

  typedef enum logic [1:0] {
    FM_IDLE,
    FM_CLEAR,
    FM_WAIT_DROP
  } fm_state_e;

  localparam int unsigned FM_MODE_LEVEL = 0;
  localparam int unsigned FM_MODE_EDGE  = 1;

endpackage

// File: rtl/cv32e40p_fault_counter.sv
// Per-source fault tracker: edge detect, saturating counter,
// sticky flag, and event-over-clear priority.
module cv32e40p_fault_counter
  import cv32e40p_fault_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned COUNT_MODE = FM_MODE_LEVEL
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 fault_i,
  input  logic                 clr_i,
  output logic                 event_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [CNT_WIDTH-1:0] cnt_nxt_o,
  output logic                 sticky_o,
  output logic                 sticky_nxt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 fault_q;
  logic                 sticky_d, sticky_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 ev;

  always_comb begin
    ev       = (COUNT_MODE == FM_MODE_EDGE) ? (fault_i & ~fault_q)
                                            : fault_i;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clr_i) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
    // An event in the clear cycle wins and counts as the first of a new run.
    if (ev) begin
      sticky_d = 1'b1;
      if (clr_i)
        cnt_d = CNT_ONE;
      else if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      fault_q  <= fault_i;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign event_o      = ev;
  assign cnt_o        = cnt_q;
  assign cnt_nxt_o    = cnt_d;
  assign sticky_o     = sticky_q;
  assign sticky_nxt_o = sticky_d;

endmodule

// File: rtl/cv32e40p_fault_monitor.sv
// Parametrised fault collector: per-source trackers plus clear
// handshake, first-fault capture and threshold alarm/irq.
module cv32e40p_fault_monitor
  import cv32e40p_fault_pkg::*;
#(
  parameter int unsigned NUM_SRC         = 3,
  parameter int unsigned CNT_WIDTH       = 8,
  parameter int unsigned ALARM_THRESHOLD = 4,
  parameter int unsigned COUNT_MODE      = FM_MODE_LEVEL,
  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_SRC-1:0]             fault_i,
  input  logic                           clear_req_i,
  input  logic [NUM_SRC-1:0]             clear_mask_i,
  output logic                           clear_ack_o,
  output logic [NUM_SRC-1:0]             fault_sticky_o,
  output logic [NUM_SRC*CNT_WIDTH-1:0]   fault_cnt_o,
  output logic                           fault_any_o,
  output logic                           first_valid_o,
  output logic [SRC_W-1:0]               first_src_o,
  output logic                           alarm_o,
  output logic                           irq_o
);

  localparam logic [CNT_WIDTH-1:0] ALARM_THR = CNT_WIDTH'(ALARM_THRESHOLD);

  fm_state_e            state_d, state_q;
  logic                 ack_d, ack_q;
  logic [NUM_SRC-1:0]   clr_vec;
  logic [NUM_SRC-1:0]   ev;
  logic [NUM_SRC-1:0]   sticky_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt [NUM_SRC];

  logic             any_d, any_q;
  logic             fv_d, fv_q;
  logic [SRC_W-1:0] fs_d, fs_q;
  logic [SRC_W-1:0] lowest;
  logic             over_thr;
  logic             alarm_d, alarm_q;
  logic             irq_d, irq_q;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    cv32e40p_fault_counter #(
      .CNT_WIDTH  (CNT_WIDTH),
      .COUNT_MODE (COUNT_MODE)
    ) u_cnt (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .fault_i      (fault_i[k]),
      .clr_i        (clr_vec[k]),
      .event_o      (ev[k]),
      .cnt_o        (fault_cnt_o[k*CNT_WIDTH +: CNT_WIDTH]),
      .cnt_nxt_o    (cnt_nxt[k]),
      .sticky_o     (fault_sticky_o[k]),
      .sticky_nxt_o (sticky_nxt[k])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FM_IDLE:      if (clear_req_i) state_d = FM_CLEAR;
      FM_CLEAR:     state_d = FM_WAIT_DROP;
      FM_WAIT_DROP: if (!clear_req_i) state_d = FM_IDLE;
      default:      state_d = FM_IDLE;
    endcase
    ack_d   = (state_d == FM_CLEAR);
    clr_vec = (state_q == FM_CLEAR) ? clear_mask_i : '0;
  end

  always_comb begin
    lowest = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (ev[k]) lowest = SRC_W'(k);
    fv_d = fv_q;
    fs_d = fs_q;
    if ((state_q == FM_CLEAR) && !(|sticky_nxt))
      fv_d = 1'b0;
    if (!fv_d && (|ev)) begin
      fv_d = 1'b1;
      fs_d = lowest;
    end
    any_d = |sticky_nxt;
  end

  // Counters only fall on a clear, so re-evaluating there is enough.
  always_comb begin
    over_thr = 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      if (cnt_nxt[k] >= ALARM_THR) over_thr = 1'b1;
    if (state_q == FM_CLEAR)
      alarm_d = over_thr;
    else
      alarm_d = alarm_q | over_thr;
    irq_d = alarm_d & ~alarm_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FM_IDLE;
      ack_q   <= 1'b0;
      any_q   <= 1'b0;
      fv_q    <= 1'b0;
      fs_q    <= '0;
      alarm_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      any_q   <= any_d;
      fv_q    <= fv_d;
      fs_q    <= fs_d;
      alarm_q <= alarm_d;
      irq_q   <= irq_d;
    end
  end

  assign clear_ack_o   = ack_q;
  assign fault_any_o   = any_q;
  assign first_valid_o = fv_q;
  assign first_src_o   = fs_q;
  assign alarm_o       = alarm_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_cv32e40p_fault_monitor.sv
// Directed bench for cv32e40p_fault_monitor: level, edge and
// saturating instances driven from vector tables and sequences.
module tb_cv32e40p_fault_monitor;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  // level instance (defaults)
  logic [2:0]  l_fault, l_mask, l_sticky;
  logic        l_req, l_ack, l_any, l_fv, l_alarm, l_irq;
  logic [23:0] l_cnt;
  logic [1:0]  l_fs;

  // edge instance
  logic [2:0]  e_fault, e_sticky;
  logic        e_ack, e_any, e_fv, e_alarm, e_irq;
  logic [23:0] e_cnt;
  logic [1:0]  e_fs;

  // saturating instance, CNT_WIDTH=2, threshold 3
  logic [2:0]  s_fault, s_sticky;
  logic        s_ack, s_any, s_fv, s_alarm, s_irq;
  logic [5:0]  s_cnt;
  logic [1:0]  s_fs;

  cv32e40p_fault_monitor u_lvl (
    .clk_i(clk), .rst_ni(rst_ni), .fault_i(l_fault),
    .clear_req_i(l_req), .clear_mask_i(l_mask), .clear_ack_o(l_ack),
    .fault_sticky_o(l_sticky), .fault_cnt_o(l_cnt), .fault_any_o(l_any),
    .first_valid_o(l_fv), .first_src_o(l_fs), .alarm_o(l_alarm),
    .irq_o(l_irq)
  );

  cv32e40p_fault_monitor #(.COUNT_MODE(1)) u_edge (
    .clk_i(clk), .rst_ni(rst_ni), .fault_i(e_fault),
    .clear_req_i(1'b0), .clear_mask_i(3'b000), .clear_ack_o(e_ack),
    .fault_sticky_o(e_sticky), .fault_cnt_o(e_cnt), .fault_any_o(e_any),
    .first_valid_o(e_fv), .first_src_o(e_fs), .alarm_o(e_alarm),
    .irq_o(e_irq)
  );

  cv32e40p_fault_monitor #(.CNT_WIDTH(2), .ALARM_THRESHOLD(3)) u_sat (
    .clk_i(clk), .rst_ni(rst_ni), .fault_i(s_fault),
    .clear_req_i(1'b0), .clear_mask_i(3'b000), .clear_ack_o(s_ack),
    .fault_sticky_o(s_sticky), .fault_cnt_o(s_cnt), .fault_any_o(s_any),
    .first_valid_o(s_fv), .first_src_o(s_fs), .alarm_o(s_alarm),
    .irq_o(s_irq)
  );

  typedef struct {
    logic [2:0]  fault;
    logic [31:0] cnt;
    logic [2:0]  sticky;
    logic        alarm;
    logic        irq;
    logic        fv;
    logic [1:0]  fs;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t lv [6];
  vec_t sv [7];
  int   acks;
  int   e_irqs;

  always @(posedge clk) if (e_irq === 1'b1) e_irqs++;

  initial begin
    lv[0] = '{3'b010, 32'h000100, 3'b010, 1'b0, 1'b0, 1'b1, 2'd1};
    lv[1] = '{3'b010, 32'h000200, 3'b010, 1'b0, 1'b0, 1'b1, 2'd1};
    lv[2] = '{3'b010, 32'h000300, 3'b010, 1'b0, 1'b0, 1'b1, 2'd1};
    lv[3] = '{3'b010, 32'h000400, 3'b010, 1'b1, 1'b1, 1'b1, 2'd1};
    lv[4] = '{3'b010, 32'h000500, 3'b010, 1'b1, 1'b0, 1'b1, 2'd1};
    lv[5] = '{3'b000, 32'h000500, 3'b010, 1'b1, 1'b0, 1'b1, 2'd1};

    sv[0] = '{3'b100, 32'h10, 3'b100, 1'b0, 1'b0, 1'b1, 2'd2};
    sv[1] = '{3'b100, 32'h20, 3'b100, 1'b0, 1'b0, 1'b1, 2'd2};
    sv[2] = '{3'b100, 32'h30, 3'b100, 1'b1, 1'b1, 1'b1, 2'd2};
    sv[3] = '{3'b100, 32'h30, 3'b100, 1'b1, 1'b0, 1'b1, 2'd2};
    sv[4] = '{3'b100, 32'h30, 3'b100, 1'b1, 1'b0, 1'b1, 2'd2};
    sv[5] = '{3'b100, 32'h30, 3'b100, 1'b1, 1'b0, 1'b1, 2'd2};
    sv[6] = '{3'b000, 32'h30, 3'b100, 1'b1, 1'b0, 1'b1, 2'd2};

    e_irqs  = 0;
    l_fault = '0; l_mask = '0; l_req = 1'b0;
    e_fault = '0; s_fault = '0;

    tick();
    tick();
    chk("rst_cnt", 32'(l_cnt), 32'h0);
    chk("rst_sticky", 32'(l_sticky), 32'h0);
    chk("rst_fv", 32'(l_fv), 32'h0);
    chk("rst_fs", 32'(l_fs), 32'h0);
    chk("rst_alarm", 32'(l_alarm), 32'h0);
    chk("rst_irq", 32'(l_irq), 32'h0);
    chk("rst_ack", 32'(l_ack), 32'h0);
    rst_ni = 1'b1;

    // level mode table
    for (int i = 0; i < 6; i++) begin
      l_fault = lv[i].fault;
      tick();
      chk($sformatf("lvl_cnt[%0d]", i), 32'(l_cnt), lv[i].cnt);
      chk($sformatf("lvl_sticky[%0d]", i), 32'(l_sticky), 32'(lv[i].sticky));
      chk($sformatf("lvl_alarm[%0d]", i), 32'(l_alarm), 32'(lv[i].alarm));
      chk($sformatf("lvl_irq[%0d]", i), 32'(l_irq), 32'(lv[i].irq));
      chk($sformatf("lvl_fv[%0d]", i), 32'(l_fv), 32'(lv[i].fv));
      chk($sformatf("lvl_fs[%0d]", i), 32'(l_fs), 32'(lv[i].fs));
    end
    chk("lvl_any", 32'(l_any), 32'h1);

    // clear mask 010 while source 1 keeps faulting: event wins
    l_fault = 3'b010; l_mask = 3'b010; l_req = 1'b1;
    tick();
    chk("clr1_ack", 32'(l_ack), 32'h1);
    chk("clr1_cnt_pre", 32'(l_cnt), 32'h000600);
    tick();
    chk("clr1_ack_drop", 32'(l_ack), 32'h0);
    chk("clr1_cnt", 32'(l_cnt), 32'h000100);
    chk("clr1_sticky", 32'(l_sticky), 32'h2);
    chk("clr1_alarm", 32'(l_alarm), 32'h0);
    chk("clr1_fv", 32'(l_fv), 32'h1);
    l_req = 1'b0; l_fault = 3'b000;
    tick();

    // clear all with request held 5 cycles: exactly one ack
    l_mask = 3'b111; l_req = 1'b1; acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (l_ack) acks++;
    end
    l_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (l_ack) acks++;
    end
    chk("clr2_acks", 32'(acks), 32'd1);
    chk("clr2_cnt", 32'(l_cnt), 32'h0);
    chk("clr2_sticky", 32'(l_sticky), 32'h0);
    chk("clr2_alarm", 32'(l_alarm), 32'h0);
    chk("clr2_fv", 32'(l_fv), 32'h0);
    chk("clr2_any", 32'(l_any), 32'h0);

    // simultaneous first faults pick the lowest index
    l_fault = 3'b110;
    tick();
    l_fault = 3'b000;
    chk("sim_fs", 32'(l_fs), 32'd1);
    chk("sim_fv", 32'(l_fv), 32'h1);
    chk("sim_sticky", 32'(l_sticky), 32'h6);
    chk("sim_cnt", 32'(l_cnt), 32'h010100);

    // edge mode: long level then two pulses
    e_fault = 3'b001;
    for (int i = 0; i < 10; i++) tick();
    chk("edge_cnt_held", 32'(e_cnt), 32'h1);
    for (int i = 0; i < 2; i++) begin
      e_fault = 3'b000;
      tick();
      e_fault = 3'b001;
      tick();
    end
    e_fault = 3'b000;
    tick();
    chk("edge_cnt", 32'(e_cnt), 32'h3);
    chk("edge_alarm", 32'(e_alarm), 32'h0);
    chk("edge_sticky", 32'(e_sticky), 32'h1);
    chk("edge_irqs", 32'(e_irqs), 32'd0);
    chk("edge_fs", 32'(e_fs), 32'd0);

    // saturation table
    for (int i = 0; i < 7; i++) begin
      s_fault = sv[i].fault;
      tick();
      chk($sformatf("sat_cnt[%0d]", i), 32'(s_cnt), sv[i].cnt);
      chk($sformatf("sat_alarm[%0d]", i), 32'(s_alarm), 32'(sv[i].alarm));
      chk($sformatf("sat_irq[%0d]", i), 32'(s_irq), 32'(sv[i].irq));
      chk($sformatf("sat_fs[%0d]", i), 32'(s_fs), 32'(sv[i].fs));
    end

    // reset while in CLEAR
    l_fault = 3'b001;
    tick();
    l_fault = 3'b000; l_mask = 3'b111; l_req = 1'b1;
    tick();
    chk("rstclr_ack_pre", 32'(l_ack), 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("rstclr_ack", 32'(l_ack), 32'h0);
    chk("rstclr_cnt", 32'(l_cnt), 32'h0);
    chk("rstclr_sticky", 32'(l_sticky), 32'h0);
    chk("rstclr_fv", 32'(l_fv), 32'h0);
    chk("rstclr_alarm", 32'(l_alarm), 32'h0);
    chk("rstclr_irq", 32'(l_irq), 32'h0);
    l_req = 1'b0;
    #2;
    rst_ni = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (l_ack) acks++;
    end
    chk("rstclr_no_ack", 32'(acks), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
